rmii_bist_gen_chk: RTL and testbench
====================================

Name: rmii_bist_gen_chk

Overview:
Parametrised RMII built-in self-test block. It generates a programmable burst of Ethernet-style frames (preamble, SFD, deterministic payload) on the RMII TX dibit interface. It also checks frames arriving on the RMII RX interface against the same payload sequence. It sits between the top-level control (UART command path or buttons) and the PHY pins, and replaces hand-driven loopback stimulus with a synthesizable generator/checker that keeps ok/error counts.

Parameters:
PAYLOAD_LEN, 64, payload bytes per frame (1..1500), no FCS.
PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD (1..7).
IFG_BYTES, 12, inter-frame gap in byte times (tx_e low).
CNT_W, 16, width of frame/ok/error counters and of the frames input.

Ports:
clk_50_mhz  in  1  RMII reference clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse: clear counters, begin burst.
stop  in  1  level: finish current frame and IFG, then go idle.
frames  in  CNT_W  frames to send; 0 = continuous until stop.
seed  in  8  payload base value, latched on start.
tx_d  out  2  RMII transmit dibit.
tx_e  out  1  RMII transmit enable.
rx_d  in  2  RMII receive dibit.
crs_dv  in  1  RMII carrier sense / data valid.
rx_er  in  1  RMII receive error.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse at end of burst.
tx_frames  out  CNT_W  frames fully transmitted.
rx_ok  out  CNT_W  frames received and matched.
rx_err  out  CNT_W  frames received with any error.

Behaviour:
- Reset: tx_d=00, tx_e=0, busy=0, done=0, all counters 0, both FSMs idle, on the first clock edge with rst=1, including mid-frame.
- Byte serialisation is LSB dibit first: b[1:0], b[3:2], b[5:4], b[7:6]. This gives 0x55 = 01,01,01,01 and SFD 0xD5 = 01,01,01,11.
- Payload byte k (0-based) of frame n (0-based within burst) = (seed + n + k) mod 256.
- TX FSM: T_IDLE -> T_PRE -> T_SFD -> T_DATA -> T_IFG -> T_PRE or T_IDLE.
  - start accepted only in T_IDLE with busy=0. tx_e=1 on the cycle after start.
  - T_PRE lasts PREAMBLE_BYTES*4 cycles, T_SFD 4 cycles, T_DATA PAYLOAD_LEN*4 cycles. tx_e=1 throughout these states.
  - T_IFG lasts IFG_BYTES*4 cycles with tx_e=0, tx_d=00. tx_frames increments on the T_DATA->T_IFG transition.
  - Leaving T_IFG: go to T_IDLE if (frames!=0 and tx_frames==frames) or stop=1, else T_PRE.
  - frames and seed are latched on start. stop is sampled only at the end of T_IFG.
- RX FSM: R_IDLE -> R_PRE -> R_DATA -> R_IDLE.
  - R_IDLE -> R_PRE when crs_dv=1 and rx_d=01.
  - In R_PRE, dibit 11 moves to R_DATA. A dibit other than 01/11 returns to R_IDLE without counting.
  - R_DATA assembles bytes and compares each one against the expected value, using frame index = rx_ok+rx_err (pre-saturation internal count).
  - On crs_dv 1->0 in R_DATA, the frame ends:
    - ok if byte count == PAYLOAD_LEN, no mismatch, no rx_er seen while crs_dv=1, and the dibit count is a multiple of 4;
    - otherwise error.
  - rx_er is ignored while crs_dv=0.
  - A frame longer than PAYLOAD_LEN bytes is an error, counted once at crs_dv fall.
- Counters saturate at 2^CNT_W-1 and never wrap. The internal frame index used for expected payload wraps mod 256.
- done: one pulse when TX reaches T_IDLE and RX is in R_IDLE, at the earliest coincident cycle. busy drops on the same cycle.
- Simultaneous start and rst: rst wins. start while busy is ignored. Counters are not cleared by a rejected start.
- stop=1 with frames!=0 still ends early at the next frame boundary.

Test Plan:
1. Loopback tx->rx (crs_dv=tx_e, rx_er=!tx_e), defaults, seed=0x10, frames=3, start pulse -> first tx dibits 01 x28 then 01,01,01,11, then payload byte 0x10 as 00,00,01,00. Afterwards tx_frames=3, rx_ok=3, rx_err=0, one done pulse, busy low.
2. Loopback with frame 1 payload byte 5 flipped (bit 0) on rx_d -> rx_ok=2, rx_err=1, tx_frames=3.
3. crs_dv forced low 8 cycles early on frame 0 (truncated, frames=1) -> rx_err=1, rx_ok=0. A one-cycle rx_er=1 while crs_dv=1 on a second run gives the same result.
4. frames=0, run, assert stop during frame 4's payload -> frame 4 completes, tx_frames=5, rx_ok=5, done pulses after IFG.
5. rst asserted mid-payload -> next cycle tx_e=0, counters 0, busy=0. A new start then produces a clean frame counted rx_ok=1.
6. CNT_W=2, frames=0, stop after 6 frames -> tx_frames=rx_ok=3 (saturated). A start pulse while busy has no effect on counters.

Source files
------------

// File: rtl/rmii_bist_gen_chk.sv
// rmii_bist_gen_chk: RMII frame burst generator and loopback payload checker with ok/error counters.
module rmii_bist_gen_chk #(
    parameter int PAYLOAD_LEN    = 64,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter int CNT_W          = 16
) (
    input  logic             clk_50_mhz,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] frames,
    input  logic [7:0]       seed,
    output logic [1:0]       tx_d,
    output logic             tx_e,
    input  logic [1:0]       rx_d,
    input  logic             crs_dv,
    input  logic             rx_er,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tx_frames,
    output logic [CNT_W-1:0] rx_ok,
    output logic [CNT_W-1:0] rx_err
);
    typedef enum logic [2:0] {T_IDLE, T_PRE, T_SFD, T_DATA, T_IFG} tx_st_t;
    typedef enum logic [1:0] {R_IDLE, R_PRE, R_DATA} rx_st_t;

    localparam logic [15:0] PRE_END  = 16'(PREAMBLE_BYTES * 4 - 1);
    localparam logic [15:0] DATA_END = 16'(PAYLOAD_LEN * 4 - 1);
    localparam logic [15:0] IFG_END  = 16'(IFG_BYTES * 4 - 1);
    localparam logic [10:0] PLEN     = 11'(PAYLOAD_LEN);
    localparam logic [CNT_W-1:0] CMAX = '1;

    tx_st_t tx_st_q, tx_st_d;
    rx_st_t rx_st_q, rx_st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0] seed_q, seed_d, tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [CNT_W-1:0] frames_q, frames_d, tx_frames_q, tx_frames_d;
    logic [CNT_W-1:0] rx_ok_q, rx_ok_d, rx_err_q, rx_err_d;
    logic busy_q, busy_d, bad_q, bad_d;
    logic [5:0] sh_q, sh_d;
    logic [1:0] dcnt_q, dcnt_d;
    logic [10:0] nb_q, nb_d;
    logic start_acc, cnt_end, last, frame_end, in_frame, byte_done, rx_end, ok;
    logic [7:0] tx_byte, rx_byte, exp_byte;

    always_comb begin
        done      = busy_q && tx_st_q == T_IDLE && rx_st_q == R_IDLE;
        busy      = busy_q && !done;
        start_acc = start && tx_st_q == T_IDLE && !busy;
        busy_d    = start_acc || busy;
        cnt_end   = tx_st_q == T_PRE  ? cnt_q == PRE_END :
                    tx_st_q == T_SFD  ? cnt_q == 16'd3 :
                    tx_st_q == T_DATA ? cnt_q == DATA_END : cnt_q == IFG_END;
        last      = (frames_q != '0 && tx_frames_q == frames_q) || stop;
        cnt_d     = (tx_st_q == T_IDLE || cnt_end) ? 16'd0 : cnt_q + 16'd1;
        tx_st_d   = tx_st_q;
        case (tx_st_q)
            T_IDLE:  if (start_acc) tx_st_d = T_PRE;
            T_PRE:   if (cnt_end) tx_st_d = T_SFD;
            T_SFD:   if (cnt_end) tx_st_d = T_DATA;
            T_DATA:  if (cnt_end) tx_st_d = T_IFG;
            default: if (cnt_end) tx_st_d = last ? T_IDLE : T_PRE;
        endcase
        frame_end   = tx_st_q == T_DATA && cnt_end;
        tx_frames_d = start_acc ? '0 : (frame_end && tx_frames_q != CMAX) ? tx_frames_q + 1'b1 : tx_frames_q;
        tx_idx_d    = start_acc ? 8'd0 : tx_idx_q + 8'(frame_end);
        seed_d      = start_acc ? seed : seed_q;
        frames_d    = start_acc ? frames : frames_q;
        tx_byte     = tx_st_q == T_PRE ? 8'h55 : tx_st_q == T_SFD ? 8'hD5 : seed_q + tx_idx_q + cnt_q[9:2];
        tx_e        = tx_st_q == T_PRE || tx_st_q == T_SFD || tx_st_q == T_DATA;
        tx_d        = tx_e ? tx_byte[{cnt_q[1:0], 1'b0} +: 2] : 2'b00;
        // Bytes arrive LSB dibit first, so the newest dibit lands on top.
        rx_byte   = {rx_d, sh_q};
        exp_byte  = seed_q + rx_idx_q + nb_q[7:0];
        sh_d      = {rx_d, sh_q[5:2]};
        in_frame  = rx_st_q == R_DATA && crs_dv;
        byte_done = in_frame && dcnt_q == 2'd3;
        rx_end    = rx_st_q == R_DATA && !crs_dv;
        ok        = nb_q == PLEN && !bad_q && dcnt_q == 2'd0;
        bad_d     = rx_st_q != R_DATA ? 1'b0 :
                    bad_q || (in_frame && rx_er) || (byte_done && (nb_q >= PLEN || rx_byte != exp_byte));
        nb_d      = rx_st_q != R_DATA ? 11'd0 : (byte_done && nb_q <= PLEN) ? nb_q + 11'd1 : nb_q;
        dcnt_d    = rx_st_q != R_DATA ? 2'd0 : dcnt_q + 2'(crs_dv);
        rx_st_d   = rx_st_q;
        case (rx_st_q)
            R_IDLE:  if (crs_dv && rx_d == 2'b01) rx_st_d = R_PRE;
            R_PRE:   rx_st_d = !crs_dv ? R_IDLE : rx_d == 2'b11 ? R_DATA : rx_d == 2'b01 ? R_PRE : R_IDLE;
            default: if (!crs_dv) rx_st_d = R_IDLE;
        endcase
        rx_ok_d   = start_acc ? '0 : (rx_end && ok && rx_ok_q != CMAX) ? rx_ok_q + 1'b1 : rx_ok_q;
        rx_err_d  = start_acc ? '0 : (rx_end && !ok && rx_err_q != CMAX) ? rx_err_q + 1'b1 : rx_err_q;
        rx_idx_d  = start_acc ? 8'd0 : rx_idx_q + 8'(rx_end);
        tx_frames = tx_frames_q;
        rx_ok     = rx_ok_q;
        rx_err    = rx_err_q;
    end

    always_ff @(posedge clk_50_mhz) begin
        if (rst) begin
            tx_st_q     <= T_IDLE;
            rx_st_q     <= R_IDLE;
            cnt_q       <= '0;
            seed_q      <= '0;
            frames_q    <= '0;
            tx_idx_q    <= '0;
            rx_idx_q    <= '0;
            tx_frames_q <= '0;
            rx_ok_q     <= '0;
            rx_err_q    <= '0;
            busy_q      <= 1'b0;
            bad_q       <= 1'b0;
            sh_q        <= '0;
            dcnt_q      <= '0;
            nb_q        <= '0;
        end else begin
            tx_st_q     <= tx_st_d;
            rx_st_q     <= rx_st_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            frames_q    <= frames_d;
            tx_idx_q    <= tx_idx_d;
            rx_idx_q    <= rx_idx_d;
            tx_frames_q <= tx_frames_d;
            rx_ok_q     <= rx_ok_d;
            rx_err_q    <= rx_err_d;
            busy_q      <= busy_d;
            bad_q       <= bad_d;
            sh_q        <= sh_d;
            dcnt_q      <= dcnt_d;
            nb_q        <= nb_d;
        end
    end
endmodule

// File: tb/tb_rmii_bist_gen_chk.sv
// tb_rmii_bist_gen_chk: loopback bench comparing generator stream and checker counts against a frame-level model.
module tb_rmii_bist_gen_chk;
    localparam int P = 64, PRE = 7, IFG = 12;
    localparam int F = (PRE + 1 + P + IFG) * 4;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst = 1'b1, start_s = 1'b0, stop_s = 1'b0, sel = 1'b0;
    logic [15:0] frames_s = '0;
    logic [7:0] seed_s = '0;
    logic [1:0] rx_xor = '0;
    logic crs_en = 1'b1, er_inj = 1'b0;

    logic [1:0] tx_d1, rx_d1, tx_d2, rx_d2;
    logic tx_e1, crs1, er1, busy1, done1, tx_e2, crs2, er2, busy2, done2;
    logic [15:0] txf1, ok1, err1;
    logic [1:0] txf2, ok2, err2;

    assign rx_d1 = tx_d1 ^ (sel ? 2'b00 : rx_xor);
    assign crs1  = tx_e1 & (sel | crs_en);
    assign er1   = !tx_e1 | (er_inj & !sel);
    assign rx_d2 = tx_d2 ^ (sel ? rx_xor : 2'b00);
    assign crs2  = tx_e2 & (!sel | crs_en);
    assign er2   = !tx_e2 | (er_inj & sel);

    rmii_bist_gen_chk dut (
        .clk_50_mhz(clk), .rst(rst), .start(start_s & !sel), .stop(stop_s & !sel),
        .frames(frames_s), .seed(seed_s), .tx_d(tx_d1), .tx_e(tx_e1),
        .rx_d(rx_d1), .crs_dv(crs1), .rx_er(er1), .busy(busy1), .done(done1),
        .tx_frames(txf1), .rx_ok(ok1), .rx_err(err1)
    );

    rmii_bist_gen_chk #(.CNT_W(2)) dut2 (
        .clk_50_mhz(clk), .rst(rst), .start(start_s & sel), .stop(stop_s & sel),
        .frames(frames_s[1:0]), .seed(seed_s), .tx_d(tx_d2), .tx_e(tx_e2),
        .rx_d(rx_d2), .crs_dv(crs2), .rx_er(er2), .busy(busy2), .done(done2),
        .tx_frames(txf2), .rx_ok(ok2), .rx_err(err2)
    );

    logic [1:0] o_tx_d;
    logic o_tx_e, o_busy, o_done;
    logic [15:0] o_txf, o_ok, o_err;
    assign o_tx_d = sel ? tx_d2 : tx_d1;
    assign o_tx_e = sel ? tx_e2 : tx_e1;
    assign o_busy = sel ? busy2 : busy1;
    assign o_done = sel ? done2 : done1;
    assign o_txf  = sel ? {14'd0, txf2} : txf1;
    assign o_ok   = sel ? {14'd0, ok2} : ok1;
    assign o_err  = sel ? {14'd0, err2} : err1;

    int n_assert = 0, n_fail = 0;
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void build(input logic [7:0] s, input int n);
        logic [7:0] b[$];
        exp_q.delete();
        for (int i = 0; i < PRE; i++) b.push_back(8'h55);
        b.push_back(8'hD5);
        for (int k = 0; k < P; k++) b.push_back(8'(int'(s) + n + k));
        foreach (b[i]) for (int d = 0; d < 4; d++) exp_q.push_back(b[i][2*d +: 2]);
    endfunction

    task automatic burst(input logic [7:0] s, input int nf, input int stop_f, input int flip_f,
                         input int flip_k, input int flip_b, input int trunc_f, input int er_f,
                         input int rs, input bit stream);
        int e, lat, lim, n, j;
        bit seen;
        e = nf == 0 ? stop_f + 1 : (stop_f >= 0 && stop_f + 1 < nf) ? stop_f + 1 : nf;
        lim = (e + 1) * F + 10;
        seed_s = s;
        frames_s = 16'(nf);
        start_s = 1'b1;
        seen = 1'b0;
        lat = -1;
        for (int t = 1; t <= lim && !seen; t++) begin
            @(negedge clk);
            n = (t - 1) / F;
            j = (t - 1) % F;
            if (t == 1) chk("busy_after_start", 32'(o_busy), 32'd1);
            if (o_done) begin
                seen = 1'b1;
                lat = t;
            end else if (stream && n < e) begin
                if (j == 0) build(s, n);
                if (j < 32 + 4 * P) begin
                    chk("tx_e_frame", 32'(o_tx_e), 32'd1);
                    chk("tx_d_frame", 32'(o_tx_d), 32'(exp_q[j]));
                end else begin
                    chk("tx_e_ifg", 32'(o_tx_e), 32'd0);
                end
            end
            start_s = (t == rs);
            stop_s  = stop_f >= 0 && (n > stop_f || (n == stop_f && j >= 40));
            rx_xor  = (n == flip_f && j == 32 + 4 * flip_k + flip_b / 2) ? 2'(1 << (flip_b % 2)) : 2'b00;
            crs_en  = !(n == trunc_f && j >= 32 + 4 * P - 8);
            er_inj  = n == er_f && j == 100;
        end
        chk("done_latency", 32'(lat), 32'(e * F + 1));
        chk("busy_at_done", 32'(o_busy), 32'd0);
        start_s = 1'b0;
        stop_s = 1'b0;
        rx_xor = 2'b00;
        crs_en = 1'b1;
        er_inj = 1'b0;
        @(negedge clk);
        chk("done_single_pulse", 32'(o_done), 32'd0);
    endtask

    initial begin
        logic [7:0] rseed;
        int rnf;
        repeat (3) @(negedge clk);
        chk("rst_tx_d", 32'(o_tx_d), 32'd0);
        chk("rst_tx_e", 32'(o_tx_e), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_txf", 32'(o_txf), 32'd0);
        chk("rst_ok", 32'(o_ok), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        burst(8'h10, 3, -1, -1, 0, 0, -1, -1, -1, 1'b1);
        chk("t1_txf", 32'(o_txf), 32'd3);
        chk("t1_ok", 32'(o_ok), 32'd3);
        chk("t1_err", 32'(o_err), 32'd0);
        burst(8'($urandom), 3, -1, 1, 5, 0, -1, -1, -1, 1'b0);
        chk("t2_txf", 32'(o_txf), 32'd3);
        chk("t2_ok", 32'(o_ok), 32'd2);
        chk("t2_err", 32'(o_err), 32'd1);
        burst(8'($urandom), 1, -1, -1, 0, 0, 0, -1, -1, 1'b0);
        chk("t3_trunc_ok", 32'(o_ok), 32'd0);
        chk("t3_trunc_err", 32'(o_err), 32'd1);
        burst(8'($urandom), 1, -1, -1, 0, 0, -1, 0, -1, 1'b0);
        chk("t3_rxer_ok", 32'(o_ok), 32'd0);
        chk("t3_rxer_err", 32'(o_err), 32'd1);
        burst(8'($urandom), 0, 4, -1, 0, 0, -1, -1, -1, 1'b1);
        chk("t4_txf", 32'(o_txf), 32'd5);
        chk("t4_ok", 32'(o_ok), 32'd5);
        chk("t4_err", 32'(o_err), 32'd0);
        rseed = 8'($urandom);
        rnf = int'($urandom_range(4, 1));
        burst(rseed, rnf, -1, int'($urandom_range(rnf - 1, 0)), int'($urandom_range(P - 1, 0)),
              int'($urandom_range(7, 0)), -1, -1, -1, 1'b1);
        chk("rand_txf", 32'(o_txf), 32'(rnf));
        chk("rand_ok", 32'(o_ok), 32'(rnf - 1));
        chk("rand_err", 32'(o_err), 32'd1);
        seed_s = 8'($urandom);
        frames_s = 16'd2;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        repeat (F + 59) @(negedge clk);
        chk("t5_txf_before_rst", 32'(o_txf), 32'd1);
        chk("t5_ok_before_rst", 32'(o_ok), 32'd1);
        chk("t5_tx_e_mid", 32'(o_tx_e), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_tx_e_after_rst", 32'(o_tx_e), 32'd0);
        chk("t5_busy_after_rst", 32'(o_busy), 32'd0);
        chk("t5_txf_after_rst", 32'(o_txf), 32'd0);
        chk("t5_ok_after_rst", 32'(o_ok), 32'd0);
        burst(8'($urandom), 1, -1, -1, 0, 0, -1, -1, -1, 1'b1);
        chk("t5_ok_restart", 32'(o_ok), 32'd1);
        chk("t5_err_restart", 32'(o_err), 32'd0);
        rst = 1'b1;
        start_s = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_s = 1'b0;
        chk("rst_wins_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("rst_wins_tx_e", 32'(o_tx_e), 32'd0);
        sel = 1'b1;
        @(negedge clk);
        burst(8'($urandom), 0, 5, -1, 0, 0, -1, -1, 1 + 5 * F + 10, 1'b1);
        chk("t6_txf_sat", 32'(o_txf), 32'd3);
        chk("t6_ok_sat", 32'(o_ok), 32'd3);
        chk("t6_err", 32'(o_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
